// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_006F;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} entries between fetch and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset here only because the head must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, FSM, halt detection and the decode queue.
// Optional build macro FETCH_PERF_EN adds push and full-stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IDX_W     = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [IDX_W-1:0] icache_addr_o,
  input  logic [31:0]      icache_inst_i,
  output logic             inst_valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  input  logic             inst_ready_i,
  output logic             halted_o,
  output logic [31:0]      monitor_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched_o,
  output logic [31:0]      perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             push, pop, flush, stall;
  entry_t           q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty;

  assign pop           = inst_valid_o & inst_ready_i;
  assign inst_valid_o  = ~q_empty;
  assign inst_o        = q_head.inst;
  assign inst_pc_o     = q_head.pc;
  assign monitor_o     = q_head.inst;
  assign halted_o      = (state_q == HALTED);
  assign icache_addr_o = pc_q[IDX_W+1:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    if (redirect_valid_i) begin
      flush   = 1'b1;
      pc_d    = redirect_pc_i & ~32'd3;
      state_d = en_i ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:   if (en_i) state_d = FETCH;
        FETCH: begin
          if (!en_i) begin
            state_d = IDLE;
          end else if (q_full && !pop) begin
            stall = 1'b1;
          end else begin
            push = 1'b1;
            // The halt word is still delivered; only the PC stops advancing.
            if (icache_inst_i == HALT_WORD) state_d = HALTED;
            else                            pc_d    = pc_q + PC_INC;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data ('{pc: pc_q, inst: icache_inst_i}),
    .rd_data (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    q_count <= CNT_W'(DEPTH));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (push)  perf_fetched_o <= perf_fetched_o + 32'd1;
      if (stall) perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed phases push expected words, a negedge monitor checks handshakes.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, redir, ready, halt_en;
  logic [31:0] redir_pc;
  logic [7:0]  icache_addr;
  logic [31:0] icache_inst;
  logic        inst_valid, halted;
  logic [31:0] inst, inst_pc, monitor;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // icache model: word equals its byte address; halt word at index 4 when enabled
  always_comb
    icache_inst = (halt_en && icache_addr == 8'h04) ? 32'h0000_006F : {22'b0, icache_addr, 2'b00};

  fetch_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .en_i             (en),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .icache_addr_o    (icache_addr),
    .icache_inst_i    (icache_inst),
    .inst_valid_o     (inst_valid),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_ready_i     (ready),
    .halted_o         (halted),
    .monitor_o        (monitor)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o   (perf_fetched),
    .perf_stall_o     (perf_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.inst = word;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed handshake must match the next expected word
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h inst %h, expected no word", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e.pc);
        check("sb_inst", inst, e.inst);
        check("sb_monitor", monitor, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0; halt_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", icache_addr, 0);

    // Stall: decode not ready, two words fill the queue, PC holds at 8
    rst = 1'b0; en = 1'b1; ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_word(32'(i * 4), 32'(i * 4));
    step();
    check("lat_c1_valid", inst_valid, 0);
    step();
    check("lat_c2_valid", inst_valid, 1);
    check("lat_c2_pc", inst_pc, 0);
    step(); step();
    check("stall_addr", icache_addr, 8'h02);
    check("stall_head", inst_pc, 0);
    step();
    check("stall_addr_hold", icache_addr, 8'h02);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", inst_valid, 1);
    end

    // Redirect flushes a full queue holding 0x10/0x14
    ready = 1'b0;
    step();
    check("full_head", inst_pc, 32'h10);
    redir = 1'b1; redir_pc = 32'h0000_0103;
    for (int i = 0; i < 4; i++) expect_word(32'h100 + 32'(i * 4), 32'h100 + 32'(i * 4));
    step();
    redir = 1'b0; ready = 1'b1;
    check("flush_valid", inst_valid, 0);
    check("redir_addr", icache_addr, 8'h40);
    step();
    check("redir_valid", inst_valid, 1);
    check("redir_pc", inst_pc, 32'h100);
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    check("drain_valid", inst_valid, 0);
    check("sb_empty_redirect", exp_q.size(), 0);

    // Halt word at pc 0x10
    halt_en = 1'b1; redir = 1'b1; redir_pc = 32'h0; en = 1'b1;
    for (int i = 0; i < 4; i++) expect_word(32'(i * 4), 32'(i * 4));
    expect_word(32'h10, 32'h0000_006F);
    step();
    redir = 1'b0;
    repeat (8) step();
    check("halt_halted", halted, 1);
    check("halt_valid", inst_valid, 0);
    check("halt_addr", icache_addr, 8'h04);
    check("sb_empty_halt", exp_q.size(), 0);
    redir = 1'b1; redir_pc = 32'h40; halt_en = 1'b0;
    expect_word(32'h40, 32'h40);
    expect_word(32'h44, 32'h44);
    step();
    redir = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_addr", icache_addr, 8'h10);
    step(); step();
    en = 1'b0;
    repeat (3) step();
    check("sb_empty_resume", exp_q.size(), 0);

    // PC and icache index wrap-around
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC; en = 1'b1;
    expect_word(32'hFFFF_FFFC, 32'h0000_03FC);
    expect_word(32'h0, 32'h0);
    step();
    redir = 1'b0;
    check("wrap_addr_ff", icache_addr, 8'hFF);
    step();
    check("wrap_addr_00", icache_addr, 8'h00);
    step();
    en = 1'b0;
    repeat (3) step();
    check("sb_empty_wrap", exp_q.size(), 0);

    // Asynchronous reset with a full queue (words 4 and 8 are never delivered)
    en = 1'b1; ready = 1'b0;
    repeat (3) step();
    check("pre_rst_valid", inst_valid, 1);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd21);
    check("perf_stall", perf_stall, 32'd3);
`endif
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", inst_valid, 0);
    check("arst_halted", halted, 0);
    check("arst_inst", inst, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_addr", icache_addr, 0);
`ifdef FETCH_PERF_EN
    check("arst_perf_fetched", perf_fetched, 0);
    check("arst_perf_stall", perf_stall, 0);
`endif
    step();
    rst = 1'b0; ready = 1'b1; en = 1'b1;
    expect_word(32'h0, 32'h0);
    expect_word(32'h4, 32'h4);
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    check("final_valid", inst_valid, 0);
    check("sb_empty_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
